// File: rtl/cpuDefine.sv
// Shared TLB definitions: geometry, page-translation item layout, op and FSM encodings.
package cpuDefine;

  localparam int TLBNUM     = 16;
  localparam int TLBNUMSIZE = $clog2(TLBNUM);

  typedef struct packed {
    logic [19:0] ppn;
    logic [1:0]  plv;
    logic [1:0]  mat;
    logic        d;
    logic        v;
  } PhytranItem;

  typedef enum logic [2:0] {
    TLB_SRCH = 3'd0,
    TLB_RD   = 3'd1,
    TLB_WR   = 3'd2,
    TLB_FILL = 3'd3,
    TLB_INV  = 3'd4
  } tlbOp_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_DONE
  } tlbState_e;

  // INVTLB op field values understood by the TLB; anything above is ignored there.
  localparam logic [2:0] INV_ALL            = 3'd0;
  localparam logic [2:0] INV_ALL_ALT        = 3'd1;
  localparam logic [2:0] INV_GLOBAL         = 3'd2;
  localparam logic [2:0] INV_NONGLOBAL      = 3'd3;
  localparam logic [2:0] INV_NONGLOBAL_ASID = 3'd4;

endpackage

// File: rtl/tlb_fill_gen.sv
// Free-running fill-index generator. Define TLB_FILL_LFSR_EN for an 8-bit LFSR,
// otherwise it is a wrap-around up-counter.
module tlb_fill_gen #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] value
);

  logic [7:0] value_q;
  logic [7:0] value_d;

`ifdef TLB_FILL_LFSR_EN
  // Fibonacci taps 8,6,5,4 folded back into bit 0.
  assign value_d = {value_q[6:0], value_q[7] ^ value_q[5] ^ value_q[4] ^ value_q[3]};
`else
  assign value_d = value_q + 8'd1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) value_q <= SEED;
    else        value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/tlb_op_ctrl.sv
// TLB instruction sequencer: accepts one op, drives a single-cycle TLB action, then
// reports completion with CSR writeback results. TLB_FILL_LFSR_EN selects the fill generator.
module tlb_op_ctrl
  import cpuDefine::*;
#(
  parameter logic [7:0] FILL_SEED = 8'hA5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic [2:0]            op_code,
  input  logic [2:0]            inv_op,
  input  logic [9:0]            inv_asid,
  input  logic [18:0]           inv_va,
  input  logic [TLBNUMSIZE-1:0] csr_index,
  input  logic [18:0]           csr_vppn,
  input  logic [9:0]            csr_asid,
  input  logic [5:0]            csr_ps,
  input  logic                  csr_ne,
  input  logic                  csr_g,
  input  PhytranItem            csr_pi0,
  input  PhytranItem            csr_pi1,
  output logic                  we,
  output logic [TLBNUMSIZE-1:0] w_index,
  output logic [5:0]            w_ps,
  output logic                  w_ne,
  output logic [9:0]            w_asid,
  output logic [18:0]           w_vppn,
  output logic                  w_g,
  output PhytranItem            w_phytran0,
  output PhytranItem            w_phytran1,
  output logic [TLBNUMSIZE-1:0] r_index,
  output logic                  fe,
  output logic [9:0]            f_asid,
  output logic [18:0]           f_va,
  output logic [2:0]            f_op,
  output logic                  srch_sel,
  output logic [18:0]           srch_vppn,
  output logic [9:0]            srch_asid,
  input  logic                  s1_ne,
  input  logic [TLBNUMSIZE-1:0] s1_index,
  input  logic [5:0]            r_ps,
  input  logic [9:0]            r_asid,
  input  logic                  r_ne,
  input  PhytranItem            r_phytran0,
  input  PhytranItem            r_phytran1,
  input  logic                  r_g,
  input  logic [18:0]           r_vppn,
  output logic                  done_valid,
  output logic [2:0]            done_op,
  output logic                  res_ne,
  output logic [TLBNUMSIZE-1:0] res_index,
  output logic [5:0]            res_ps,
  output logic [9:0]            res_asid,
  output logic [18:0]           res_vppn,
  output logic                  res_g,
  output PhytranItem            res_pi0,
  output PhytranItem            res_pi1
);

  tlbState_e state_q, state_d;

  logic [2:0]            opCode_q;
  logic [2:0]            invOp_q;
  logic [9:0]            invAsid_q;
  logic [18:0]           invVa_q;
  logic [TLBNUMSIZE-1:0] csrIndex_q;
  logic [18:0]           csrVppn_q;
  logic [9:0]            csrAsid_q;
  logic [5:0]            csrPs_q;
  logic                  csrNe_q;
  logic                  csrG_q;
  PhytranItem            csrPi0_q;
  PhytranItem            csrPi1_q;
  logic [7:0]            fillValue;
  logic                  accept;

  tlb_fill_gen #(.SEED(FILL_SEED)) u_fill_gen (
    .clk   (clk),
    .reset (reset),
    .value (fillValue)
  );

  assign accept = (state_q == ST_IDLE) && op_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Exactly one TLB strobe fires, and only while in EXEC; undefined ops fire none.
  always_comb begin
    state_d  = state_q;
    we       = 1'b0;
    fe       = 1'b0;
    srch_sel = 1'b0;
    case (state_q)
      ST_IDLE: if (op_valid) state_d = ST_EXEC;
      ST_EXEC: begin
        state_d = ST_DONE;
        case (opCode_q)
          TLB_SRCH:         srch_sel = 1'b1;
          TLB_WR, TLB_FILL: we       = 1'b1;
          TLB_INV:          fe       = 1'b1;
          default:          ;
        endcase
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      opCode_q   <= '0;
      invOp_q    <= '0;
      invAsid_q  <= '0;
      invVa_q    <= '0;
      csrIndex_q <= '0;
      csrVppn_q  <= '0;
      csrAsid_q  <= '0;
      csrPs_q    <= '0;
      csrNe_q    <= 1'b0;
      csrG_q     <= 1'b0;
      csrPi0_q   <= '0;
      csrPi1_q   <= '0;
    end else if (accept) begin
      opCode_q   <= op_code;
      invOp_q    <= inv_op;
      invAsid_q  <= inv_asid;
      invVa_q    <= inv_va;
      csrIndex_q <= csr_index;
      csrVppn_q  <= csr_vppn;
      csrAsid_q  <= csr_asid;
      csrPs_q    <= csr_ps;
      csrNe_q    <= csr_ne;
      csrG_q     <= csr_g;
      csrPi0_q   <= csr_pi0;
      csrPi1_q   <= csr_pi1;
    end
  end

  // Results are sampled on the EXEC->DONE edge; a read miss scrubs the stale entry image.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_ne    <= 1'b0;
      res_index <= '0;
      res_ps    <= '0;
      res_asid  <= '0;
      res_vppn  <= '0;
      res_g     <= 1'b0;
      res_pi0   <= '0;
      res_pi1   <= '0;
    end else if (state_q == ST_EXEC) begin
      if (opCode_q == TLB_SRCH) begin
        res_ne    <= s1_ne;
        res_index <= s1_index;
      end else if (opCode_q == TLB_RD) begin
        res_ne   <= r_ne;
        res_ps   <= r_ne ? '0 : r_ps;
        res_asid <= r_ne ? '0 : r_asid;
        res_vppn <= r_ne ? '0 : r_vppn;
        res_g    <= r_ne ? 1'b0 : r_g;
        res_pi0  <= r_ne ? '0 : r_phytran0;
        res_pi1  <= r_ne ? '0 : r_phytran1;
      end
    end
  end

  // TLBNUM is a power of two, so the low bits of the generator are the modulus.
  assign w_index    = (opCode_q == TLB_FILL) ? fillValue[TLBNUMSIZE-1:0] : csrIndex_q;
  assign w_ps       = csrPs_q;
  assign w_ne       = csrNe_q;
  assign w_asid     = csrAsid_q;
  assign w_vppn     = csrVppn_q;
  assign w_g        = csrG_q;
  assign w_phytran0 = csrPi0_q;
  assign w_phytran1 = csrPi1_q;
  assign r_index    = csrIndex_q;
  assign f_op       = invOp_q;
  assign f_asid     = invAsid_q;
  assign f_va       = invVa_q;
  assign srch_vppn  = csrVppn_q;
  assign srch_asid  = csrAsid_q;
  assign op_ready   = (state_q == ST_IDLE);
  assign done_valid = (state_q == ST_DONE);
  assign done_op    = opCode_q;

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Directed testbench for tlb_op_ctrl with a small behavioural TLB attached to its TLB ports.
module tb_tlb_op_ctrl;
  import cpuDefine::*;

  logic clk;
  logic reset;
  logic op_valid, op_ready;
  logic [2:0] op_code, inv_op;
  logic [9:0] inv_asid;
  logic [18:0] inv_va;
  logic [3:0] csr_index;
  logic [18:0] csr_vppn;
  logic [9:0] csr_asid;
  logic [5:0] csr_ps;
  logic csr_ne, csr_g;
  PhytranItem csr_pi0, csr_pi1;
  logic we, fe, srch_sel, w_ne, w_g, s1_ne, r_ne, r_g, done_valid, res_ne, res_g;
  logic [3:0] w_index, r_index, s1_index, res_index;
  logic [5:0] w_ps, r_ps, res_ps;
  logic [9:0] w_asid, f_asid, srch_asid, r_asid, res_asid;
  logic [18:0] w_vppn, f_va, srch_vppn, r_vppn, res_vppn;
  logic [2:0] f_op, done_op;
  PhytranItem w_phytran0, w_phytran1, r_phytran0, r_phytran1, res_pi0, res_pi1;

  int checkCount = 0;
  int failCount  = 0;

  localparam PhytranItem PI0 = '{ppn: 20'h12345, plv: 2'd3, mat: 2'd1, d: 1'b1, v: 1'b1};
  localparam PhytranItem PI1 = '{ppn: 20'h0ABCD, plv: 2'd0, mat: 2'd2, d: 1'b0, v: 1'b1};

  tlb_op_ctrl #(.FILL_SEED(8'hA5)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
    .inv_op(inv_op), .inv_asid(inv_asid), .inv_va(inv_va),
    .csr_index(csr_index), .csr_vppn(csr_vppn), .csr_asid(csr_asid), .csr_ps(csr_ps),
    .csr_ne(csr_ne), .csr_g(csr_g), .csr_pi0(csr_pi0), .csr_pi1(csr_pi1),
    .we(we), .w_index(w_index), .w_ps(w_ps), .w_ne(w_ne), .w_asid(w_asid), .w_vppn(w_vppn),
    .w_g(w_g), .w_phytran0(w_phytran0), .w_phytran1(w_phytran1), .r_index(r_index),
    .fe(fe), .f_asid(f_asid), .f_va(f_va), .f_op(f_op),
    .srch_sel(srch_sel), .srch_vppn(srch_vppn), .srch_asid(srch_asid),
    .s1_ne(s1_ne), .s1_index(s1_index),
    .r_ps(r_ps), .r_asid(r_asid), .r_ne(r_ne), .r_phytran0(r_phytran0), .r_phytran1(r_phytran1),
    .r_g(r_g), .r_vppn(r_vppn),
    .done_valid(done_valid), .done_op(done_op),
    .res_ne(res_ne), .res_index(res_index), .res_ps(res_ps), .res_asid(res_asid),
    .res_vppn(res_vppn), .res_g(res_g), .res_pi0(res_pi0), .res_pi1(res_pi1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural TLB: invalidation only clears the valid bit, so stale data stays readable.
  logic        mE    [16];
  logic [18:0] mVppn [16];
  logic [9:0]  mAsid [16];
  logic [5:0]  mPs   [16];
  logic        mG    [16];
  PhytranItem  mPi0  [16];
  PhytranItem  mPi1  [16];

  initial for (int i = 0; i < 16; i++) mE[i] = 1'b0;

  always @(posedge clk) begin
    if (we) begin
      mE[w_index]    <= ~w_ne;
      mVppn[w_index] <= w_vppn;
      mAsid[w_index] <= w_asid;
      mPs[w_index]   <= w_ps;
      mG[w_index]    <= w_g;
      mPi0[w_index]  <= w_phytran0;
      mPi1[w_index]  <= w_phytran1;
    end
    if (fe) begin
      for (int i = 0; i < 16; i++) begin
        case (f_op)
          3'd0, 3'd1: mE[i] <= 1'b0;
          3'd2: if (mG[i]) mE[i] <= 1'b0;
          3'd3: if (!mG[i]) mE[i] <= 1'b0;
          3'd4: if (!mG[i] && mAsid[i] == f_asid) mE[i] <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  assign r_ne       = ~mE[r_index];
  assign r_vppn     = mVppn[r_index];
  assign r_asid     = mAsid[r_index];
  assign r_ps       = mPs[r_index];
  assign r_g        = mG[r_index];
  assign r_phytran0 = mPi0[r_index];
  assign r_phytran1 = mPi1[r_index];

  always_comb begin
    s1_ne    = 1'b1;
    s1_index = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (mE[i] && mVppn[i] == srch_vppn && (mG[i] || mAsid[i] == srch_asid)) begin
        s1_ne    = 1'b0;
        s1_index = i[3:0];
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Presents an op at a negedge, waits for acceptance, and returns at the EXEC-cycle negedge.
  task automatic applyStimulus(input logic [2:0] code, input logic [3:0] idx,
                               input logic [18:0] vppn, input logic [9:0] asid,
                               input logic [2:0] iop);
    int waitCycles;
    op_code   = code;
    inv_op    = iop;
    inv_asid  = asid;
    inv_va    = vppn;
    csr_index = idx;
    csr_vppn  = vppn;
    csr_asid  = asid;
    csr_ps    = 6'd12;
    csr_ne    = 1'b0;
    csr_g     = 1'b0;
    csr_pi0   = PI0;
    csr_pi1   = PI1;
    op_valid  = 1'b1;
    waitCycles = 0;
    while (!op_ready && waitCycles < 20) begin
      waitCycles++;
      @(negedge clk);
    end
    if (!op_ready) checkOutput("accept_timeout", 32'(op_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  task automatic waitDone(input logic [2:0] expectOp);
    @(negedge clk);
    checkOutput("done_valid", 32'(done_valid), 32'd1);
    checkOutput("done_op", 32'(done_op), 32'(expectOp));
    checkOutput("strobes_in_done", {29'd0, we, fe, srch_sel}, 32'd0);
    @(negedge clk);
    checkOutput("done_pulse_end", 32'(done_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lowCount, weSeen, doneSeen;
    reset = 1'b0; op_valid = 1'b0; op_code = '0; inv_op = '0; inv_asid = '0; inv_va = '0;
    csr_index = '0; csr_vppn = '0; csr_asid = '0; csr_ps = '0; csr_ne = 1'b0; csr_g = 1'b0;
    csr_pi0 = '0; csr_pi1 = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_op_ready", 32'(op_ready), 32'd1);
    checkOutput("rst_strobes", {28'd0, we, fe, srch_sel, done_valid}, 32'd0);
    checkOutput("rst_res", {12'd0, res_ne, res_vppn}, 32'd0);
    checkOutput("rst_latch_index", 32'(r_index), 32'd0);

    // FILL accepted on the third edge after release lands on (0xA5+3)%16.
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    applyStimulus(3'd3, 4'd0, 19'h0AAA, 10'd3, 3'd0);
    checkOutput("fill_we", 32'(we), 32'd1);
    checkOutput("fill_index", 32'(w_index), 32'd8);
    waitDone(3'd3);

    applyStimulus(3'd2, 4'd5, 19'h1234, 10'd7, 3'd0);
    checkOutput("wr_we", 32'(we), 32'd1);
    checkOutput("wr_index", 32'(w_index), 32'd5);
    checkOutput("wr_vppn", 32'(w_vppn), 32'h1234);
    checkOutput("wr_asid", 32'(w_asid), 32'd7);
    waitDone(3'd2);

    applyStimulus(3'd1, 4'd5, 19'h0, 10'd0, 3'd0);
    checkOutput("rd_r_index", 32'(r_index), 32'd5);
    checkOutput("rd_no_we", 32'(we), 32'd0);
    waitDone(3'd1);
    checkOutput("rd_res_vppn", 32'(res_vppn), 32'h1234);
    checkOutput("rd_res_asid", 32'(res_asid), 32'd7);
    checkOutput("rd_res_ne", 32'(res_ne), 32'd0);
    checkOutput("rd_res_ps", 32'(res_ps), 32'd12);
    checkOutput("rd_res_pi0", 32'(res_pi0), 32'(PI0));

    applyStimulus(3'd0, 4'd0, 19'h1234, 10'd7, 3'd0);
    checkOutput("srch_sel", 32'(srch_sel), 32'd1);
    checkOutput("srch_vppn", 32'(srch_vppn), 32'h1234);
    waitDone(3'd0);
    checkOutput("srch_hit_ne", 32'(res_ne), 32'd0);
    checkOutput("srch_hit_index", 32'(res_index), 32'd5);

    applyStimulus(3'd0, 4'd0, 19'h7777, 10'd7, 3'd0);
    waitDone(3'd0);
    checkOutput("srch_miss_ne", 32'(res_ne), 32'd1);

    applyStimulus(3'd4, 4'd0, 19'h0, 10'd0, 3'd0);
    checkOutput("inv_fe", 32'(fe), 32'd1);
    checkOutput("inv_f_op", 32'(f_op), 32'd0);
    waitDone(3'd4);

    applyStimulus(3'd1, 4'd5, 19'h0, 10'd0, 3'd0);
    waitDone(3'd1);
    checkOutput("rdmiss_ne", 32'(res_ne), 32'd1);
    checkOutput("rdmiss_vppn_asid", {3'd0, res_vppn, res_asid}, 32'd0);
    checkOutput("rdmiss_ps_g", {25'd0, res_ps, res_g}, 32'd0);
    checkOutput("rdmiss_pi", 32'(res_pi0) | 32'(res_pi1), 32'd0);

    applyStimulus(3'd4, 4'd0, 19'h0, 10'd0, 3'd7);
    checkOutput("inv7_fe", 32'(fe), 32'd1);
    checkOutput("inv7_f_op", 32'(f_op), 32'd7);
    waitDone(3'd4);

    applyStimulus(3'd5, 4'd2, 19'h0, 10'd0, 3'd0);
    checkOutput("undef_strobes", {29'd0, we, fe, srch_sel}, 32'd0);
    waitDone(3'd5);

    // Second op held from the first op's EXEC cycle is taken once op_ready returns.
    applyStimulus(3'd2, 4'd3, 19'h0333, 10'd1, 3'd0);
    csr_index = 4'd4;
    op_valid  = 1'b1;
    lowCount  = 0;
    while (!op_ready && lowCount < 10) begin
      lowCount++;
      @(negedge clk);
    end
    checkOutput("b2b_ready_low", 32'(lowCount), 32'd2);
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0;
    checkOutput("b2b_we", 32'(we), 32'd1);
    checkOutput("b2b_index", 32'(w_index), 32'd4);
    weSeen = 0;
    repeat (6) begin
      @(negedge clk);
      if (we) weSeen++;
    end
    checkOutput("b2b_once", 32'(weSeen), 32'd0);

    // Reset in the middle of a WR kills the write and the completion.
    applyStimulus(3'd2, 4'd6, 19'h0666, 10'd2, 3'd0);
    checkOutput("abort_we_before", 32'(we), 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("abort_we_in_reset", 32'(we), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    weSeen = 0;
    doneSeen = 0;
    repeat (4) begin
      @(negedge clk);
      if (we) weSeen++;
      if (done_valid) doneSeen++;
    end
    checkOutput("abort_no_we", 32'(weSeen), 32'd0);
    checkOutput("abort_no_done", 32'(doneSeen), 32'd0);
    checkOutput("abort_ready", 32'(op_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/tlb_op_ctrl.md
TLB_OP_CTRL -- requirements
Module: tlb_op_ctrl

Interface
REQ-001 SHALL have parameter FILL_SEED, default 8'hA5, giving the fill-index generator reset value.
REQ-002 SHALL have port clk, input, 1 bit: the single clock.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port op_valid, input, 1 bit: a TLB instruction is presented.
REQ-005 SHALL have port op_ready, output, 1 bit: high when the controller can accept an op.
REQ-006 SHALL have port op_code, input, 3 bits: SRCH=0, RD=1, WR=2, FILL=3, INV=4.
REQ-007 SHALL have ports inv_op (3 bits), inv_asid (10 bits) and inv_va (19 bits), all inputs: the INVTLB operands.
REQ-008 SHALL have ports csr_index (TLBNUMSIZE bits), csr_vppn (19), csr_asid (10), csr_ps (6), csr_ne (1), csr_g (1), csr_pi0 and csr_pi1 (PhytranItem), all inputs: the CSR-side entry image.
REQ-009 SHALL have TLB-side outputs we, w_index, w_ps, w_ne, w_asid, w_vppn, w_g, w_phytran0, w_phytran1, r_index, fe, f_asid, f_va and f_op, matching the TLB port widths.
REQ-010 SHALL have outputs srch_sel (1), srch_vppn (19) and srch_asid (10), which take over TLB search port 1; inputs s1_ne and s1_index return the search result.
REQ-011 SHALL have inputs r_ps, r_asid, r_ne, r_phytran0, r_phytran1, r_g and r_vppn: the TLB read data.
REQ-012 SHALL have outputs done_valid (1) and done_op (3), plus result outputs res_ne, res_index, res_ps, res_asid, res_vppn, res_g, res_pi0 and res_pi1 for CSR writeback.

Function
REQ-013 SHALL implement the FSM IDLE -> EXEC -> DONE -> IDLE; op_ready=1 only in IDLE.
REQ-014 SHALL accept an op on op_valid&&op_ready and latch op_code, the inv_* operands and the csr_* fields.
REQ-015 SHALL, in EXEC, drive exactly one TLB action for a single cycle; all TLB strobes SHALL be 0 in IDLE and DONE.
REQ-016 SRCH: SHALL assert srch_sel with the latched vppn/asid; at the end of EXEC SHALL capture s1_ne into res_ne and s1_index into res_index.
REQ-017 RD: SHALL drive r_index=latched index; at the end of EXEC SHALL capture the r_* inputs into res_*. When r_ne=1, res_ps/asid/vppn/g/pi SHALL be 0.
REQ-018 WR: SHALL assert we with w_index=latched index and the w_* fields from the latched CSR image.
REQ-019 FILL: as WR, except w_index = fill generator value mod TLBNUM.
REQ-020 INV: SHALL assert fe with f_op/f_asid/f_va from the latch; inv_op values 7..5 outside the TLB's defined set SHALL still pulse fe (the TLB ignores them).
REQ-021 SHALL, in DONE, pulse done_valid for 1 cycle with done_op; res_* SHALL hold until the next accepted op.
REQ-022 Latency: accept at cycle N, TLB action at N+1, done_valid at N+2, next accept possible at N+3.
REQ-023 Undefined op_code values (5..7) SHALL pass through EXEC with no TLB strobe and complete normally.
REQ-024 The fill generator SHALL advance every clock regardless of FSM state.

Reset
REQ-025 While reset=0: state=IDLE, op_ready=1, and we=fe=srch_sel=done_valid=0.
REQ-026 While reset=0: all res_*=0, all latches=0, and the fill generator=FILL_SEED.
REQ-027 Reset asserted mid-op SHALL abort the op: no we/fe pulse after release, and no done_valid.

Configuration
REQ-028 With TLB_FILL_LFSR_EN defined, the fill generator SHALL be an 8-bit Fibonacci LFSR, taps 8,6,5,4, shifting left with feedback into bit 0.
REQ-029 Without TLB_FILL_LFSR_EN, the fill generator SHALL be an 8-bit wrap-around up-counter.

Structure
REQ-030 The op_code encoding enum and the FSM state enum SHALL reside in package cpuDefine, alongside TLBNUM, TLBNUMSIZE, PhytranItem and the INVTLB op constants.
REQ-031 The fill generator SHALL be sub-module tlb_fill_gen (clk, reset, value[7:0]).

Verification
REQ-032 Reset release, counter mode, FILL_SEED=0xA5, TLBNUM=16: FILL accepted on the 3rd cycle after release -> w_index=(0xA5+3)%16=8, we for exactly 1 cycle.
REQ-033 WR index 5, vppn 0x1234, asid 7, then RD index 5 -> res_vppn=0x1234, res_asid=7, res_ne=0; done_valid 2 cycles after each accept.
REQ-034 SRCH vppn 0x1234, asid 7 after REQ-033 -> res_ne=0, res_index=5; SRCH vppn 0x7777 -> res_ne=1.
REQ-035 INV inv_op=0 -> fe=1 for 1 cycle with f_op=0; a subsequent RD of index 5 -> res_ne=1 and all other res_*=0.
REQ-036 op_valid held high for back-to-back ops -> op_ready low for 2 cycles per op; an op held while op_ready=0 is accepted exactly once, when op_ready returns.
REQ-037 reset pulsed low during EXEC of a WR -> no we after release, no done_valid, op_ready=1.
